// File: rtl/mips32_pkg.sv
// Shared encodings for the MIPS32 memory stage: control bit positions,
// access sizes, FSM states and the default bus timeout.
package mips32_pkg;

    localparam int CTL_MEM_READ   = 0;
    localparam int CTL_MEM_WRITE  = 1;
    localparam int CTL_BRANCH     = 2;
    localparam int CTL_REG_WRITE  = 3;
    localparam int CTL_MEM_TO_REG = 4;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ERR    = 2'b10
    } state_t;

    // The unused encoding 11 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'b11) ? 2'b00 : s;
    endfunction

    function automatic logic misaligned(input logic [1:0] s, input logic [1:0] lane);
        case (norm_size(s))
            SZ_HALF: return lane[0];
            SZ_BYTE: return 1'b0;
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables and lane replication, plus load
// lane selection with zero/sign extension.
module mem_align
    import mips32_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_data_i[7:0];
        case (lane_i)
            2'd1:    ld_byte = ld_data_i[15:8];
            2'd2:    ld_byte = ld_data_i[23:16];
            2'd3:    ld_byte = ld_data_i[31:24];
            default: ld_byte = ld_data_i[7:0];
        endcase
        ld_half = lane_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];

        be_o      = 4'b1111;
        st_data_o = st_data_i;
        ld_data_o = ld_data_i;
        case (norm_size(size_i))
            SZ_HALF: begin
                be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
                ld_data_o = {{16{sign_i & ld_half[15]}}, ld_half};
            end
            SZ_BYTE: begin
                be_o      = 4'b0001 << lane_i;
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = {{24{sign_i & ld_byte[7]}}, ld_byte};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: branch resolve, data-memory access FSM with alignment
// check and bus timeout, and the MEM/WB pipeline register.
module mem_stage
    import mips32_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flag_zero_in,
    input  logic [4:0]  control_in,
    input  logic [1:0]  size_in,
    input  logic        sign_in,
    input  logic [31:0] branch_address_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rt_value_in,
    input  logic [4:0]  dest_reg_in,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic [1:0]  wb_control_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  dest_reg_out,
    output logic        align_err,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          done_q, done_d;
    logic          issue;

    logic [31:0] addr_q, wdat_q;
    logic [1:0]  size_q;
    logic        sign_q, we_q, rd_q, m2r_q, rw_q;
    logic [4:0]  dest_q;

    logic [1:0]  wb_q, wb_d;
    logic [31:0] rdata_q, rdata_d, alu_q, alu_d;
    logic [4:0]  wbdest_q, wbdest_d;

    logic        mem_op, stall_c, berr_c;
    logic [31:0] ld_ext;

    assign mem_op        = control_in[CTL_MEM_READ] | control_in[CTL_MEM_WRITE];
    assign pc_src        = control_in[CTL_BRANCH] & flag_zero_in;
    assign branch_target = branch_address_in;

    mem_align u_align (
        .size_i    (size_q),
        .lane_i    (addr_q[1:0]),
        .sign_i    (sign_q),
        .st_data_i (wdat_q),
        .ld_data_i (dmem.dmem_rdata),
        .be_o      (dmem.dmem_be),
        .st_data_o (dmem.dmem_wdata),
        .ld_data_o (ld_ext)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        done_d   = 1'b0;
        issue    = 1'b0;
        stall_c  = 1'b0;
        berr_c   = 1'b0;
        wb_d     = 2'b00;
        rdata_d  = '0;
        alu_d    = '0;
        wbdest_d = '0;
        case (state_q)
            ST_IDLE: begin
                // done_q: EX/MEM still holds the access just retired while
                // stalled; let it drain instead of issuing it twice.
                if (done_q) begin
                end else if (mem_op && misaligned(size_in, alu_result_in[1:0])) begin
                    state_d  = ST_ERR;
                    wb_d     = {control_in[CTL_MEM_TO_REG], 1'b0};
                    alu_d    = alu_result_in;
                    wbdest_d = dest_reg_in;
                end else if (mem_op) begin
                    state_d = ST_ACCESS;
                    wait_d  = '0;
                    issue   = 1'b1;
                    stall_c = 1'b1;
                end else begin
                    wb_d     = {control_in[CTL_MEM_TO_REG], control_in[CTL_REG_WRITE]};
                    alu_d    = alu_result_in;
                    wbdest_d = dest_reg_in;
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    wb_d     = {m2r_q, rw_q};
                    rdata_d  = rd_q ? ld_ext : 32'h0;
                    alu_d    = addr_q;
                    wbdest_d = dest_q;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    berr_c  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_ERR: begin
                stall_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            done_q   <= 1'b0;
            wb_q     <= '0;
            rdata_q  <= '0;
            alu_q    <= '0;
            wbdest_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            done_q   <= done_d;
            wb_q     <= wb_d;
            rdata_q  <= rdata_d;
            alu_q    <= alu_d;
            wbdest_q <= wbdest_d;
        end
    end

    // Request is captured at issue so dmem_* stay stable through ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            wdat_q <= '0;
            size_q <= '0;
            sign_q <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            m2r_q  <= 1'b0;
            rw_q   <= 1'b0;
            dest_q <= '0;
        end else if (issue) begin
            addr_q <= alu_result_in;
            wdat_q <= rt_value_in;
            size_q <= norm_size(size_in);
            sign_q <= sign_in;
            we_q   <= control_in[CTL_MEM_WRITE];
            rd_q   <= control_in[CTL_MEM_READ];
            m2r_q  <= control_in[CTL_MEM_TO_REG];
            rw_q   <= control_in[CTL_REG_WRITE];
            dest_q <= dest_reg_in;
        end
    end

    assign dmem.dmem_req  = (state_q == ST_ACCESS);
    assign dmem.dmem_we   = dmem.dmem_req & we_q;
    assign dmem.dmem_addr = {addr_q[31:2], 2'b00};

    assign stall          = stall_c & ~rst;
    assign bus_err        = berr_c;
    assign align_err      = (state_q == ST_ERR);
    assign wb_control_out = wb_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign dest_reg_out   = wbdest_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized instruction stream against a transaction-level model of the
// MEM stage, plus directed scenarios with hand-computed expectations.
module tb_mem_stage;
    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_zero_in;
    logic [4:0]  control_in;
    logic [1:0]  size_in;
    logic        sign_in;
    logic [31:0] branch_address_in, alu_result_in, rt_value_in;
    logic [4:0]  dest_reg_in;
    logic        pc_src, stall, align_err, bus_err;
    logic [31:0] branch_target, read_data_out, alu_result_out;
    logic [1:0]  wb_control_out;
    logic [4:0]  dest_reg_out;

    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flag_zero_in(flag_zero_in), .control_in(control_in),
        .size_in(size_in), .sign_in(sign_in), .branch_address_in(branch_address_in),
        .alu_result_in(alu_result_in), .rt_value_in(rt_value_in), .dest_reg_in(dest_reg_in),
        .pc_src(pc_src), .branch_target(branch_target), .stall(stall), .dmem(bus),
        .wb_control_out(wb_control_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .dest_reg_out(dest_reg_out),
        .align_err(align_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [1:0]  wb;
        bit          full;
        bit          chk_rd;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dest;
    } mwb_t;

    typedef struct {
        bit          stall, req, aerr, berr, we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
    } cyc_t;

    int   vectors = 0, miscompares = 0;
    bit   chk_en = 0, err_pending = 0;
    mwb_t cur_mwb;
    cyc_t ex;

    int          obs_stalls;
    bit          obs_req_any, obs_aerr, obs_berr, obs_bus_taken, obs_we, obs_pc;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_rd, obs_bt;
    logic [1:0]  obs_wb, obs_err_wb;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic mwb_t mk(input logic [1:0] wb, input bit full, input bit crd,
                                input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] dest);
        mwb_t m;
        m.wb = wb; m.full = full; m.chk_rd = crd; m.rd = rd; m.alu = alu; m.dest = dest;
        return m;
    endfunction

    function automatic logic [1:0] nsz(input logic [1:0] s);
        return (s == 2'b11) ? 2'b00 : s;
    endfunction

    function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
        case (nsz(s))
            2'b00:   return a[1:0] != 2'b00;
            2'b01:   return a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
        case (nsz(s))
            2'b10:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] s, input logic [31:0] rt);
        case (nsz(s))
            2'b10:   return {4{rt[7:0]}};
            2'b01:   return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] s, input bit sg, input logic [31:0] a,
                                         input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * a[1:0]);
        case (nsz(s))
            2'b10:   return {{24{sg & v[7]}}, v[7:0]};
            2'b01:   return {{16{sg & v[15]}}, v[15:0]};
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) if (chk_en) begin
        cmp("pc_src", 32'(pc_src), 32'(control_in[2] & flag_zero_in));
        cmp("branch_target", branch_target, branch_address_in);
        cmp("stall", 32'(stall), 32'(ex.stall));
        cmp("dmem_req", 32'(bus.dmem_req), 32'(ex.req));
        cmp("align_err", 32'(align_err), 32'(ex.aerr));
        cmp("bus_err", 32'(bus_err), 32'(ex.berr));
        if (ex.req) begin
            cmp("dmem_addr", bus.dmem_addr, ex.addr);
            cmp("dmem_be", 32'(bus.dmem_be), 32'(ex.be));
            cmp("dmem_wdata", bus.dmem_wdata, ex.wdata);
            cmp("dmem_we", 32'(bus.dmem_we), 32'(ex.we));
        end
        cmp("wb_control", 32'(wb_control_out), 32'(cur_mwb.wb));
        if (cur_mwb.full) begin
            cmp("alu_result_out", alu_result_out, cur_mwb.alu);
            cmp("dest_reg_out", 32'(dest_reg_out), 32'(cur_mwb.dest));
        end
        if (cur_mwb.chk_rd) cmp("read_data_out", read_data_out, cur_mwb.rd);
    end

    // One clock of the stream: expectations for this cycle, memory response
    // for this cycle, and what MEM/WB must hold after the edge.
    task automatic cyc(input bit st, input bit rq, input bit ae, input bit be_, input mwb_t nxt,
                       input bit ack, input logic [31:0] rdata);
        ex.stall = st; ex.req = rq; ex.aerr = ae; ex.berr = be_;
        bus.dmem_ack = ack; bus.dmem_rdata = rdata;
        chk_en = 1;
        @(negedge clk);
        if (stall) obs_stalls++;
        obs_req_any |= bus.dmem_req; obs_aerr |= align_err; obs_berr |= bus_err;
        if (bus.dmem_req && !obs_bus_taken) begin
            obs_be = bus.dmem_be; obs_wdata = bus.dmem_wdata; obs_we = bus.dmem_we;
            obs_bus_taken = 1;
        end
        if (align_err) obs_err_wb = wb_control_out;
        obs_wb = wb_control_out; obs_rd = read_data_out; obs_pc = pc_src; obs_bt = branch_target;
        @(posedge clk); #1;
        cur_mwb = nxt;
    endtask

    // d = ACCESS cycle carrying the ack; d > TO means no ack at all.
    task automatic do_instr(input logic [4:0] ctl, input logic [1:0] sz, input bit sg,
                            input logic [31:0] ea, input logic [31:0] rt, input logic [4:0] dst,
                            input bit fz, input logic [31:0] ba, input int d, input logic [31:0] rdat);
        mwb_t bub, res;
        bub = mk(2'b00, 0, 0, 0, 0, 0);
        obs_stalls = 0; obs_req_any = 0; obs_aerr = 0; obs_berr = 0; obs_bus_taken = 0;
        control_in = ctl; size_in = sz; sign_in = sg; alu_result_in = ea; rt_value_in = rt;
        dest_reg_in = dst; flag_zero_in = fz; branch_address_in = ba;
        if (err_pending) begin
            err_pending = 0;
            cyc(1, 0, 1, 0, bub, 1'($urandom), $urandom);
        end
        if (!(ctl[0] | ctl[1])) begin
            cyc(0, 0, 0, 0, mk({ctl[4], ctl[3]}, 1, 0, 0, ea, dst), 1'($urandom), $urandom);
        end else if (misal(sz, ea)) begin
            cyc(0, 0, 0, 0, mk({ctl[4], 1'b0}, 1, 0, 0, ea, dst), 1'($urandom), $urandom);
            err_pending = 1;
        end else begin
            ex.we = ctl[1]; ex.addr = {ea[31:2], 2'b00}; ex.be = m_be(sz, ea); ex.wdata = m_wd(sz, rt);
            cyc(1, 0, 0, 0, bub, 1'($urandom), $urandom);
            for (int k = 1; k <= TO; k++) begin
                if (k == d) begin
                    res = mk({ctl[4], ctl[3]}, 1, ctl[0], ctl[0] ? m_ld(sz, sg, ea, rdat) : 32'h0, ea, dst);
                    cyc(1, 1, 0, 0, res, 1, rdat);
                    break;
                end else if (k == TO) begin
                    cyc(1, 1, 0, 1, bub, 0, $urandom);
                end else begin
                    cyc(1, 1, 0, 0, bub, 0, $urandom);
                end
            end
            cyc(0, 0, 0, 0, bub, 1'($urandom), $urandom);
        end
    endtask

    initial begin
        cur_mwb = mk(2'b00, 1, 1, 0, 0, 0);
        ex = '{default: 0};
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
        rst = 1;
        control_in = 5'b01001; size_in = 2'b00; sign_in = 0; alu_result_in = 32'h100;
        rt_value_in = 0; dest_reg_in = 5'd3; flag_zero_in = 0; branch_address_in = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_stall", 32'(stall), 0);
        cmp("rst_req", 32'(bus.dmem_req), 0);
        cmp("rst_we", 32'(bus.dmem_we), 0);
        cmp("rst_errs", 32'({align_err, bus_err}), 0);
        cmp("rst_wb", 32'(wb_control_out), 0);
        cmp("rst_mwb", read_data_out | alu_result_out | 32'(dest_reg_out), 0);
        rst = 0;

        // Branch resolve
        do_instr(5'b00100, 2'b00, 0, 32'h55, 0, 5'd1, 1, 32'h40, 0, 0);
        cmp("dir_branch_pc_src", 32'(obs_pc), 1);
        cmp("dir_branch_target", obs_bt, 32'h40);
        cmp("dir_branch_no_req", 32'(obs_req_any), 0);

        // lb 0x1003, signed, ack on the second ACCESS cycle
        do_instr(5'b11001, 2'b10, 1, 32'h1003, 0, 5'd7, 0, 0, 2, 32'h80FFFFFF);
        cmp("dir_lb_stalls", obs_stalls, 3);
        cmp("dir_lb_rdata", obs_rd, 32'hFFFFFF80);
        cmp("dir_lb_wb", 32'(obs_wb), 32'h3);

        // sh 0x2002
        do_instr(5'b00010, 2'b01, 0, 32'h2002, 32'h1234ABCD, 5'd0, 0, 0, 1, 0);
        cmp("dir_sh_be", 32'(obs_be), 32'hC);
        cmp("dir_sh_wdata", obs_wdata, 32'hABCDABCD);
        cmp("dir_sh_we", 32'(obs_we), 1);

        // lw 0x0001 misaligned; ERR cycle lands on the following nop
        do_instr(5'b11001, 2'b00, 0, 32'h1, 0, 5'd4, 0, 0, 1, 0);
        cmp("dir_mis_req", 32'(obs_req_any), 0);
        do_instr(5'b00000, 2'b00, 0, 32'h8, 0, 5'd0, 0, 0, 0, 0);
        cmp("dir_mis_aerr", 32'(obs_aerr), 1);
        cmp("dir_mis_wb", 32'(obs_err_wb), 32'h2);
        cmp("dir_mis_stalls", obs_stalls, 1);
        cmp("dir_mis_req2", 32'(obs_req_any), 0);

        // Timeout, then ack on the timeout cycle
        do_instr(5'b11001, 2'b00, 0, 32'h300, 0, 5'd9, 0, 0, TO + 1, 0);
        cmp("dir_to_berr", 32'(obs_berr), 1);
        cmp("dir_to_wb", 32'(obs_wb), 0);
        cmp("dir_to_stalls", obs_stalls, TO + 1);
        do_instr(5'b11001, 2'b00, 0, 32'h304, 0, 5'd9, 0, 0, TO, 32'hCAFE0001);
        cmp("dir_toack_berr", 32'(obs_berr), 0);
        cmp("dir_toack_wb", 32'(obs_wb), 32'h3);
        cmp("dir_toack_rd", obs_rd, 32'hCAFE0001);

        // Reset in the middle of an access
        chk_en = 0;
        control_in = 5'b11001; size_in = 2'b00; alu_result_in = 32'h400; bus.dmem_ack = 0;
        @(posedge clk); #1;
        cmp("rstmid_req_before", 32'(bus.dmem_req), 1);
        #2 rst = 1;
        #1;
        cmp("rstmid_req", 32'(bus.dmem_req), 0);
        cmp("rstmid_stall", 32'(stall), 0);
        cmp("rstmid_errs", 32'({align_err, bus_err}), 0);
        cmp("rstmid_mwb", read_data_out | alu_result_out | 32'(dest_reg_out) | 32'(wb_control_out), 0);
        @(posedge clk); #1;
        control_in = 5'b00000; rst = 0;
        cur_mwb = mk(2'b00, 1, 1, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [4:0]  ctl;
            logic [1:0]  sz;
            logic [31:0] ea;
            int          kind, r, d;
            kind = $urandom_range(0, 3);
            ctl = 5'($urandom);
            case (kind)
                0:       ctl[1:0] = 2'b00;
                1:       ctl[1:0] = 2'b01;
                2:       ctl[1:0] = 2'b10;
                default: ctl[1:0] = 2'($urandom_range(1, 3));
            endcase
            sz = 2'($urandom);
            ea = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (nsz(sz) == 2'b00) ea[1:0] = 2'b00;
                if (nsz(sz) == 2'b01) ea[0] = 1'b0;
            end
            r = $urandom_range(0, 7);
            d = (r == 0) ? TO + 1 : (r == 1) ? TO : $urandom_range(1, 3);
            do_instr(ctl, sz, 1'($urandom), ea, $urandom, 5'($urandom), 1'($urandom), $urandom, d, $urandom);
        end
        if (err_pending) do_instr(5'b00000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 255, meaning the maximum number of wait cycles for dmem_ack before the access is aborted.
REQ-002 The block SHALL expose these ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flag_zero_in  in  1  ALU zero flag from EX/MEM.
- control_in  in  5  {mem_to_reg, reg_write, branch, mem_write, mem_read}, bit 4 to bit 0.
- size_in  in  2  access size: 00 word, 01 half, 10 byte.
- sign_in  in  1  sign-extend sub-word loads.
- branch_address_in  in  32  branch target.
- alu_result_in  in  32  effective address or ALU value.
- rt_value_in  in  32  store data.
- dest_reg_in  in  5  write-back register index.
- pc_src  out  1  take branch.
- branch_target  out  32  branch target to fetch.
- stall  out  1  freeze IF/ID/EX and EX/MEM.
- dmem_req, dmem_we  out  1 each  memory request and write enable.
- dmem_addr  out  32  word-aligned address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completion.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- wb_control_out  out  2  {mem_to_reg, reg_write}.
- read_data_out, alu_result_out  out  32 each  MEM/WB values.
- dest_reg_out  out  5  MEM/WB destination.
- align_err, bus_err  out  1 each  one-cycle exception pulses.

Function
REQ-003 pc_src SHALL equal branch AND flag_zero_in combinationally; branch_target SHALL equal branch_address_in.
REQ-004 Non-memory instructions (mem_read = mem_write = 0) SHALL load the MEM/WB outputs on the next rising edge with stall low (1-cycle latency).
REQ-005 The FSM SHALL have states IDLE, ACCESS, ERR.
REQ-006 IDLE -> ACCESS SHALL occur when mem_read or mem_write is set and the address is aligned; stall SHALL be high combinationally in that same cycle.
REQ-007 In ACCESS, dmem_req SHALL be high and all dmem_* outputs SHALL be held stable until dmem_ack is sampled high.
REQ-008 stall SHALL stay high through every ACCESS cycle, including the cycle dmem_ack is sampled.
REQ-009 On the ack edge, the FSM SHALL return to IDLE and MEM/WB SHALL capture the instruction, with aligned load data in read_data_out.
REQ-010 During stall cycles, MEM/WB SHALL hold a bubble: wb_control_out = 00.
REQ-011 Byte enables and store data SHALL follow alu_result_in[1:0] and size_in as follows:
- word: 1111.
- half: 0011 or 1100.
- byte: one-hot lane.
- dmem_wdata: byte or half replicated across all lanes.
REQ-012 Load extraction SHALL select the addressed lane, then zero- or sign-extend it per sign_in.
REQ-013 Misalignment (word with addr[1:0] != 00, half with addr[0] != 0) SHALL go to ERR for one cycle. In that case:
- no dmem_req is issued;
- align_err pulses;
- the instruction is written to MEM/WB with reg_write forced to 0;
- stall is high for that one cycle.
- ERR -> IDLE follows unconditionally.
REQ-014 A wait counter SHALL count ACCESS cycles. When it reaches TIMEOUT without an ack:
- the access is aborted and bus_err pulses;
- the bubble rule applies and reg_write is forced to 0;
- the FSM returns to IDLE.
- An ack arriving in the same cycle as the timeout SHALL win.
REQ-015 dmem_ack while in IDLE SHALL be ignored.
REQ-016 size_in = 11 SHALL be treated as word.

Reset
REQ-017 While rst is high, the block SHALL hold:
- FSM in IDLE and wait counter at 0;
- dmem_req, dmem_we, stall, align_err, bus_err at 0;
- wb_control_out, read_data_out, alu_result_out, dest_reg_out at 0.
REQ-018 Reset during ACCESS SHALL abandon the request immediately with no error pulse.

Structure
REQ-019 Package mips32_pkg SHALL hold:
- control bit indices;
- size encodings;
- FSM state encoding;
- TIMEOUT default.
REQ-020 Lane selection and extension SHALL live in a combinational sub-module mem_align, used for both the store and load paths.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- Branch: control = 00100, flag_zero = 1, target 0x40 -> pc_src = 1, branch_target = 0x40, no dmem_req.
- Byte load: lb at 0x1003 with sign, dmem_rdata = 0x80FFFFFF, ack after 2 cycles -> 3 stall cycles, read_data_out = 0xFFFFFF80, wb_control = 11.
- Halfword store: sh at 0x2002, rt = 0x1234ABCD -> dmem_be = 1100, dmem_wdata = 0xABCDABCD, dmem_we = 1.
- Misaligned load: lw at 0x0001 -> align_err pulse, no dmem_req, wb_control = 10, stall 1 cycle.
- Bus timeout: no ack -> bus_err on the timeout cycle, then IDLE; a repeat run with the ack on that cycle -> normal completion, no error.
- Reset mid-access: rst asserted in ACCESS -> dmem_req and stall drop at once, outputs return to 0.
